// File: rtl/fifo_wr_arbiter_if.sv
// Requester and FIFO write-side bundle for fifo_wr_arbiter.
// The master modport is the arbiter's view. The slave modport is the view of the
// producers and FIFO that connect to it.
interface fifo_wr_arbiter_if #(
    parameter int WIDTH = 8,
    parameter int NREQ  = 4
);
    localparam int IDW = $clog2(NREQ);

    logic [NREQ-1:0]       REQ_VALID;
    logic [NREQ-1:0]       REQ_LAST;
    logic [NREQ*WIDTH-1:0] REQ_DATA;
    logic [NREQ-1:0]       REQ_READY;
    logic [WIDTH-1:0]      FIFO_D;
    logic                  FIFO_WR;
    logic                  FIFO_FULL;
    logic [IDW-1:0]        GRANT_ID;
    logic                  BUSY;

    modport master (
        input  REQ_VALID, REQ_LAST, REQ_DATA, FIFO_FULL,
        output REQ_READY, FIFO_D, FIFO_WR, GRANT_ID, BUSY
    );

    modport slave (
        output REQ_VALID, REQ_LAST, REQ_DATA, FIFO_FULL,
        input  REQ_READY, FIFO_D, FIFO_WR, GRANT_ID, BUSY
    );
endinterface

// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter that shares one FIFO write port among NREQ producers.
// A grant lasts until one of three events: the packet ends, BURST_MAX words
// have moved, or the producer goes idle. A full FIFO stalls the grant and
// never releases it.
// Optional macro FIFO_ARB_PRIO_EN: requester 0 wins every arbitration it
// takes part in, and its grants leave the round-robin pointer untouched.
module fifo_wr_arbiter #(
    parameter int WIDTH     = 8,
    parameter int NREQ      = 4,
    parameter int BURST_MAX = 4
) (
    input  logic               CLK,
    input  logic               RST,
    fifo_wr_arbiter_if.master  bus
);
    localparam int IDW = $clog2(NREQ);
    localparam int CW  = $clog2(BURST_MAX + 1);

    typedef enum logic {IDLE, BURST} state_t;

    state_t           state_q, state_d;
    logic [IDW-1:0]   rr_ptr_q, rr_ptr_d;
    logic [CW-1:0]    burst_cnt_q, burst_cnt_d;
    logic [IDW-1:0]   grant_q, grant_d;
`ifdef FIFO_ARB_PRIO_EN
    logic             prio_q, prio_d;
`endif

    logic [IDW-1:0]   win;
    logic             any_valid;
    logic [NREQ-1:0]  ready_c;
    logic             wr_c;
    logic [WIDTH-1:0] d_c;
    logic             g_valid;
    logic             g_last;
    logic             xfer;
    logic [CW-1:0]    cnt_inc;
    logic             release_c;
    logic [IDW-1:0]   next_ptr;

    // Pick the first valid requester, scanning upward from rr_ptr with wrap.
    always_comb begin
        int idx;
        logic found;
        win       = '0;
        found     = 1'b0;
        idx       = 0;
        any_valid = |bus.REQ_VALID;
        for (int k = 0; k < NREQ; k++) begin
            idx = (int'(rr_ptr_q) + k) % NREQ;
            if (!found && bus.REQ_VALID[idx]) begin
                found = 1'b1;
                win   = IDW'(idx);
            end
        end
`ifdef FIFO_ARB_PRIO_EN
        if (bus.REQ_VALID[0]) begin
            win = '0;
        end
`endif
    end

    // Next-state logic and the outputs for the granted requester.
    always_comb begin
        state_d     = state_q;
        rr_ptr_d    = rr_ptr_q;
        burst_cnt_d = burst_cnt_q;
        grant_d     = grant_q;
`ifdef FIFO_ARB_PRIO_EN
        prio_d      = prio_q;
`endif
        ready_c     = '0;
        wr_c        = 1'b0;
        d_c         = '0;
        g_valid     = bus.REQ_VALID[grant_q];
        g_last      = bus.REQ_LAST[grant_q];
        xfer        = 1'b0;
        cnt_inc     = burst_cnt_q + 1'b1;
        release_c   = 1'b0;
        next_ptr    = (grant_q == IDW'(NREQ - 1)) ? '0 : grant_q + 1'b1;

        case (state_q)
            IDLE: begin
                if (any_valid) begin
                    grant_d     = win;
                    burst_cnt_d = '0;
                    state_d     = BURST;
`ifdef FIFO_ARB_PRIO_EN
                    prio_d      = bus.REQ_VALID[0];
`endif
                end
            end
            BURST: begin
                ready_c[grant_q] = ~bus.FIFO_FULL;
                wr_c             = g_valid & ~bus.FIFO_FULL;
                d_c              = bus.REQ_DATA[int'(grant_q)*WIDTH +: WIDTH];
                xfer             = g_valid & ~bus.FIFO_FULL;
                if (xfer) begin
                    burst_cnt_d = cnt_inc;
                end
                // A stalled FIFO blocks every release condition, including idle.
                release_c = (xfer & (g_last | (cnt_inc == CW'(BURST_MAX))))
                          | (~g_valid & ~bus.FIFO_FULL);
                if (release_c) begin
                    state_d = IDLE;
`ifdef FIFO_ARB_PRIO_EN
                    if (!prio_q) begin
                        rr_ptr_d = next_ptr;
                    end
`else
                    rr_ptr_d = next_ptr;
`endif
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Control state register. A reset in the middle of a burst abandons the burst.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q     <= IDLE;
            rr_ptr_q    <= '0;
            burst_cnt_q <= '0;
            grant_q     <= '0;
`ifdef FIFO_ARB_PRIO_EN
            prio_q      <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            rr_ptr_q    <= rr_ptr_d;
            burst_cnt_q <= burst_cnt_d;
            grant_q     <= grant_d;
`ifdef FIFO_ARB_PRIO_EN
            prio_q      <= prio_d;
`endif
        end
    end

    // Handshake outputs stay quiet while reset is held, so the reset cycle moves no data.
    assign bus.REQ_READY = RST ? '0 : ready_c;
    assign bus.FIFO_WR   = RST ? 1'b0 : wr_c;
    assign bus.FIFO_D    = RST ? '0 : d_c;
    assign bus.GRANT_ID  = grant_q;
    assign bus.BUSY      = (state_q == BURST);
endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Directed bench for fifo_wr_arbiter. Per-requester word queues feed the
// producers. An expected-write queue is filled as stimulus is issued, and a
// monitor checks every FIFO write against it.
module tb_fifo_wr_arbiter;
    localparam int WIDTH = 8;
    localparam int NREQ  = 4;

    logic CLK = 1'b0;
    logic RST;

    fifo_wr_arbiter_if #(.WIDTH(WIDTH), .NREQ(NREQ)) bus ();

    fifo_wr_arbiter #(.WIDTH(WIDTH), .NREQ(NREQ), .BURST_MAX(4)) dut (
        .CLK(CLK),
        .RST(RST),
        .bus(bus)
    );

    always #5 CLK = ~CLK;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc   = 0;
    int first_wr = -1;
    int last_wr  = -1;
    int acc_cnt[NREQ];

    logic [8:0]  src[NREQ][$];  // {last, data}
    logic [11:0] exp_q[$];      // {grant id, data}

    always @(posedge CLK) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got %0h, required %0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    task automatic push_word(input int id, input logic [7:0] d, input logic last);
        src[id].push_back({last, d});
    endtask

    task automatic expect_wr(input int id, input logic [7:0] d);
        exp_q.push_back({4'(id), d});
    endtask

    // Producer driver: take the handshake at negedge and advance the queues after the edge.
    initial begin
        logic [NREQ-1:0] acc;
        logic [NREQ-1:0] v, l;
        logic [NREQ*WIDTH-1:0] d;
        logic [8:0] e;
        for (int i = 0; i < NREQ; i++) acc_cnt[i] = 0;
        bus.REQ_VALID = '0;
        bus.REQ_LAST  = '0;
        bus.REQ_DATA  = '0;
        forever begin
            @(negedge CLK);
            acc = bus.REQ_VALID & bus.REQ_READY;
            @(posedge CLK);
            #2;
            v = '0; l = '0; d = '0;
            for (int i = 0; i < NREQ; i++) begin
                if (acc[i] && src[i].size() > 0) begin
                    void'(src[i].pop_front());
                    acc_cnt[i]++;
                end
                if (src[i].size() > 0) begin
                    e = src[i][0];
                    v[i] = 1'b1;
                    l[i] = e[8];
                    d[i*WIDTH +: WIDTH] = e[7:0];
                end
            end
            bus.REQ_VALID = v;
            bus.REQ_LAST  = l;
            bus.REQ_DATA  = d;
        end
    end

    // Scoreboard monitor: every FIFO write must match the next expected word.
    initial begin
        logic [11:0] e;
        forever begin
            @(negedge CLK);
            if (bus.FIFO_WR === 1'b1) begin
                check("wr_while_full", {31'b0, bus.FIFO_FULL}, 32'd0);
                if (exp_q.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL unexpected_write: got data %0h grant %0h, required no write", bus.FIFO_D, bus.GRANT_ID);
                end else begin
                    e = exp_q.pop_front();
                    check("wr_data", {24'b0, bus.FIFO_D}, {24'b0, e[7:0]});
                    check("wr_grant", {30'b0, bus.GRANT_ID}, {28'b0, e[11:8]});
                end
                if (first_wr < 0) first_wr = cyc;
                last_wr = cyc;
            end
        end
    end

    task automatic wait_drain(input int limit);
        int k;
        k = 0;
        while (exp_q.size() != 0 && k < limit) begin
            @(negedge CLK);
            #1;
            k++;
        end
        check("drain_remaining", exp_q.size(), 0);
    endtask

    task automatic wait_acc(input int id, input int n);
        int k;
        k = 0;
        while (acc_cnt[id] < n && k < 200) begin
            @(posedge CLK);
            #3;
            k++;
        end
        check("accept_count", acc_cnt[id], n);
    endtask

    task automatic wait_valid(input int id);
        int k;
        k = 0;
        do begin
            @(negedge CLK);
            k++;
        end while (bus.REQ_VALID[id] !== 1'b1 && k < 20);
        check("valid_rise", {31'b0, bus.REQ_VALID[id]}, 32'd1);
    endtask

    // Called just after a posedge. Holds reset for one cycle and checks outputs during and after it.
    task automatic pulse_rst();
        RST = 1'b1;
        @(negedge CLK);
        check("rst_ready", {28'b0, bus.REQ_READY}, 32'd0);
        check("rst_wr", {31'b0, bus.FIFO_WR}, 32'd0);
        @(posedge CLK);
        #1;
        RST = 1'b0;
        @(negedge CLK);
        check("post_rst_busy", {31'b0, bus.BUSY}, 32'd0);
        check("post_rst_grant", {30'b0, bus.GRANT_ID}, 32'd0);
        check("post_rst_ready", {28'b0, bus.REQ_READY}, 32'd0);
        check("post_rst_wr", {31'b0, bus.FIFO_WR}, 32'd0);
        check("post_rst_d", {24'b0, bus.FIFO_D}, 32'd0);
    endtask

    initial begin
        int base;
        RST = 1'b1;
        bus.FIFO_FULL = 1'b0;
        repeat (3) @(posedge CLK);
        #1;
        RST = 1'b0;
        @(negedge CLK);
        check("reset_ready", {28'b0, bus.REQ_READY}, 32'd0);
        check("reset_wr", {31'b0, bus.FIFO_WR}, 32'd0);
        check("reset_busy", {31'b0, bus.BUSY}, 32'd0);
        check("reset_grant", {30'b0, bus.GRANT_ID}, 32'd0);
        check("reset_d", {24'b0, bus.FIFO_D}, 32'd0);

        // Single requester 2: three words, LAST on the third.
        @(posedge CLK);
        #3;
        first_wr = -1;
        push_word(2, 8'h21, 1'b0);
        push_word(2, 8'h22, 1'b0);
        push_word(2, 8'h23, 1'b1);
        expect_wr(2, 8'h21);
        expect_wr(2, 8'h22);
        expect_wr(2, 8'h23);
        wait_valid(2);
        @(posedge CLK);
        @(negedge CLK);
        check("t1_grant", {30'b0, bus.GRANT_ID}, 32'd2);
        check("t1_busy", {31'b0, bus.BUSY}, 32'd1);
        check("t1_first_wr", {31'b0, bus.FIFO_WR}, 32'd1);
        wait_drain(50);
        @(posedge CLK);
        #1;
        check("t1_idle", {31'b0, bus.BUSY}, 32'd0);
        check("t1_rr_ptr", {30'b0, dut.rr_ptr_q}, 32'd3);
        check("t1_consecutive", last_wr - first_wr, 32'd2);

        // Reset restores rr_ptr to 0 before the all-requesters run.
        @(posedge CLK);
        #3;
        pulse_rst();

        // All four valid, no LAST: bursts of four words in order 0,1,2,3,0.
        @(posedge CLK);
        #3;
        first_wr = -1;
        for (int w = 0; w < 8; w++) push_word(0, 8'(w), 1'b0);
        for (int i = 1; i < NREQ; i++)
            for (int w = 0; w < 4; w++) push_word(i, 8'(i * 16 + w), 1'b0);
        for (int i = 0; i < NREQ; i++)
            for (int w = 0; w < 4; w++) expect_wr(i, 8'(i * 16 + w));
        for (int w = 4; w < 8; w++) expect_wr(0, 8'(w));
        wait_drain(100);
        check("t2_span", last_wr - first_wr, 32'd23);

        // FIFO full for five cycles after word 2 of requester 1.
        @(posedge CLK);
        #3;
        base = acc_cnt[1];
        push_word(1, 8'h1A, 1'b0);
        push_word(1, 8'h1B, 1'b0);
        push_word(1, 8'h1C, 1'b0);
        push_word(1, 8'h1D, 1'b0);
        expect_wr(1, 8'h1A);
        expect_wr(1, 8'h1B);
        expect_wr(1, 8'h1C);
        expect_wr(1, 8'h1D);
        wait_acc(1, base + 2);
        bus.FIFO_FULL = 1'b1;
        for (int k = 0; k < 5; k++) begin
            @(negedge CLK);
            check("t3_ready_full", {28'b0, bus.REQ_READY}, 32'd0);
            check("t3_wr_full", {31'b0, bus.FIFO_WR}, 32'd0);
            check("t3_grant_kept", {30'b0, bus.GRANT_ID}, 32'd1);
            check("t3_busy_kept", {31'b0, bus.BUSY}, 32'd1);
        end
        @(posedge CLK);
        #1;
        bus.FIFO_FULL = 1'b0;
        wait_drain(50);

        // Requester 3 sends one word and then goes idle. Requesters 1 and 2 follow.
        @(posedge CLK);
        #3;
        base = acc_cnt[3];
        push_word(3, 8'h31, 1'b0);
        expect_wr(3, 8'h31);
        wait_acc(3, base + 1);
        push_word(1, 8'h15, 1'b0);
        push_word(1, 8'h16, 1'b1);
        push_word(2, 8'h25, 1'b1);
        expect_wr(1, 8'h15);
        expect_wr(1, 8'h16);
        expect_wr(2, 8'h25);
        wait_drain(50);

        // Reset during requester 2's burst. Arbitration afterwards starts again from 0.
        @(posedge CLK);
        #3;
        base = acc_cnt[2];
        push_word(2, 8'h41, 1'b0);
        push_word(2, 8'h42, 1'b0);
        push_word(2, 8'h43, 1'b0);
        push_word(2, 8'h44, 1'b0);
        expect_wr(2, 8'h41);
        expect_wr(2, 8'h42);
        wait_acc(2, base + 2);
        push_word(3, 8'h35, 1'b1);
        expect_wr(2, 8'h43);
        expect_wr(2, 8'h44);
        expect_wr(3, 8'h35);
        pulse_rst();
        wait_drain(50);

        repeat (4) @(posedge CLK);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation still running at cycle %0d, required completion", cyc);
        $fatal(1, "watchdog");
    end
endmodule

// File: doc/fifo_wr_arbiter.md
Name: fifo_wr_arbiter

Overview:
- Shares the write port of one synchronous FIFO among NREQ producers using round-robin arbitration with bounded bursts.
- Each producer has a valid/ready handshake. The block drives the FIFO's WR/D pins and backs off on FIFO FULL.
- Sits between the NN engine's producer lanes (PE result streams) and the shared output FIFO.

Parameters:
- WIDTH, 8, data width per requester and of the FIFO data bus.
- NREQ, 4, number of requesters (2..16).
- BURST_MAX, 4, maximum words transferred per grant (1..255).

Ports:
- CLK  in  1  system clock.
- RST  in  1  synchronous reset, active-high.
- REQ_VALID  in  NREQ  per-requester data valid.
- REQ_LAST  in  NREQ  per-requester end-of-packet marker, qualified by valid.
- REQ_DATA  in  NREQ*WIDTH  requester i data on bits [i*WIDTH +: WIDTH].
- REQ_READY  out  NREQ  per-requester ready; one-hot or zero.
- FIFO_D  out  WIDTH  data to FIFO D.
- FIFO_WR  out  1  write request to FIFO WR.
- FIFO_FULL  in  1  FIFO FULL flag.
- GRANT_ID  out  clog2(NREQ)  index of the current/last granted requester.
- BUSY  out  1  high while in state BURST.

Behaviour:
- Reset, synchronous, active-high, clock CLK:
  - state=IDLE, rr_ptr=0, burst_cnt=0, GRANT_ID=0, BUSY=0.
  - REQ_READY=0, FIFO_WR=0 (forced low while RST is high).
  - FIFO_D=0 while in IDLE.
  - Reset mid-burst aborts the burst. No transfer is counted in the reset cycle.
- States: IDLE, BURST.
- IDLE:
  - If any REQ_VALID is set, select the first valid index scanning rr_ptr, rr_ptr+1, ... modulo NREQ.
  - Register the winner into GRANT_ID, clear burst_cnt, go to BURST next cycle.
  - No ready is asserted in IDLE. Arbitration latency is 1 cycle, so the first write is possible on cycle 2 after valid rises.
- BURST, with g=GRANT_ID:
  - REQ_READY[g] = ~FIFO_FULL; all other ready bits are 0.
  - FIFO_WR = REQ_VALID[g] & ~FIFO_FULL, combinational. FIFO_D = REQ_DATA[g] (mux, combinational).
  - Transfer = REQ_VALID[g] & REQ_READY[g]. Each transfer increments burst_cnt, width clog2(BURST_MAX+1).
- Release from BURST to IDLE, at the clock edge after any of:
  - (a) a transfer with REQ_LAST[g]=1;
  - (b) a transfer that makes burst_cnt reach BURST_MAX;
  - (c) REQ_VALID[g]=0 in a BURST cycle with FIFO_FULL=0.
- On release: rr_ptr=(g+1) mod NREQ. GRANT_ID holds its value in IDLE until the next win.
- FIFO_FULL in BURST:
  - Ready and WR are held low and the grant is kept; no release on stall.
  - Valid dropping while full does not release.
- Simultaneous: LAST on the BURST_MAX-th word gives a single release; rr_ptr is updated once.
- Wrap: rr_ptr wraps from NREQ-1 to 0. burst_cnt never exceeds BURST_MAX.
- FIFO_WR is never asserted while FIFO_FULL=1, so every FIFO_WR pulse is a committed write.

Optional Feature:
- Macro FIFO_ARB_PRIO_EN.
- Defined: in IDLE, requester 0 wins whenever REQ_VALID[0]=1, regardless of rr_ptr. A requester-0 win does not update rr_ptr on release. Other requesters use round-robin as above.
- Undefined: pure round-robin for all requesters.

Test Plan:
- Single requester: REQ_VALID[2]=1, 3 words, LAST on word 3, FIFO not full -> GRANT_ID=2 after 1 cycle; FIFO_WR high 3 consecutive cycles with data in order; return to IDLE; rr_ptr=3.
- All 4 valid continuously, no LAST, BURST_MAX=4 -> grants in order 0,1,2,3,0; each grant gives exactly 4 writes; one IDLE cycle between bursts.
- FIFO_FULL asserted for 5 cycles mid-burst on requester 1 after word 2 -> REQ_READY[1]=0, FIFO_WR=0 for those 5 cycles; grant retained; words 3-4 written after FULL drops; no data lost or duplicated.
- Requester 3 drops valid after 1 word with FIFO not full -> release; next grant goes to the lowest valid index scanning from 0.
- RST pulsed for 1 cycle mid-burst -> next cycle IDLE; REQ_READY=0, FIFO_WR=0, GRANT_ID=0; arbitration restarts from requester 0.
- With FIFO_ARB_PRIO_EN, requesters 0 and 2 valid, rr_ptr=2 -> requester 0 granted; after its release requester 2 is granted; rr_ptr stays 2 until requester 2 releases (then 3).
